// File: rtl/herv_rf_ram_pkg.sv
// herv_rf_ram_pkg
// Shared sizing helpers for the register-file RAM and its bus interface,
// plus the clear/run state encoding used by herv_rf_ram.
package herv_rf_ram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rf_state_e;

   // Total bits needed for 32 GPRs plus the CSR shadow registers.
   function automatic int unsigned raw_bits(input int unsigned csr_regs);
      return 32 * (32 + csr_regs);
   endfunction

   function automatic int unsigned l2w(input int unsigned width);
      return $clog2(width);
   endfunction

   // Word count rounded up to a power of two so the address is a clean field.
   function automatic int unsigned calc_depth(input int unsigned width,
                                              input int unsigned csr_regs);
      return 1 << $clog2((raw_bits(csr_regs) + width - 1) / width);
   endfunction

   function automatic int unsigned calc_aw(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/herv_rf_if.sv
// herv_rf_if
// Register-file RAM bus: one write port, one read port, init status.
//   i_waddr/i_wdata/i_wen : write word address, data, strobe
//   i_raddr/i_ren         : read word address, strobe
//   o_rdata               : registered read data
//   o_init_done           : clear sequence finished
// master = core side, slave = RAM side.
interface herv_rf_if
   import herv_rf_ram_pkg::*;
#(
   parameter int unsigned width    = 16,
   parameter int unsigned csr_regs = 4,
   parameter int unsigned depth    = calc_depth(width, csr_regs)
);
   localparam int unsigned aw = calc_aw(depth);

   logic [aw-1:0]    i_waddr;
   logic [width-1:0] i_wdata;
   logic             i_wen;
   logic [aw-1:0]    i_raddr;
   logic             i_ren;
   logic [width-1:0] o_rdata;
   logic             o_init_done;

   modport master (
      output i_waddr, i_wdata, i_wen, i_raddr, i_ren,
      input  o_rdata, o_init_done
   );

   modport slave (
      input  i_waddr, i_wdata, i_wen, i_raddr, i_ren,
      output o_rdata, o_init_done
   );
endinterface

// File: rtl/herv_rf_ram_sram.sv
// herv_rf_sram
// Plain 1W/1R synchronous RAM with a registered, read-first read port.
// Kept separate so a foundry macro can drop in. No reset on the array or
// the read register.
//   i_clk   : clock
//   i_wen/i_waddr/i_wdata : write port
//   i_ren/i_raddr         : read port, o_q updates on the edge when i_ren=1
module herv_rf_sram #(
   parameter int unsigned width = 16,
   parameter int unsigned depth = 128,
   parameter int unsigned aw    = 7
) (
   input  logic             i_clk,
   input  logic             i_wen,
   input  logic [aw-1:0]    i_waddr,
   input  logic [width-1:0] i_wdata,
   input  logic             i_ren,
   input  logic [aw-1:0]    i_raddr,
   output logic [width-1:0] o_q
);
   logic [width-1:0] r_mem [depth];

   // Non-blocking array update makes a same-address read return the old word.
   always_ff @(posedge i_clk) begin
      if (i_wen) r_mem[i_waddr] <= i_wdata;
      if (i_ren) o_q <= r_mem[i_raddr];
   end
endmodule

// File: rtl/herv_rf_ram.sv
// herv_rf_ram
// Register-file RAM wrapper: clears every word after reset, then passes
// core reads/writes to the storage array, dropping writes to x0.
//   i_clk   : clock
//   i_rst_n : async active-low reset
//   bus     : herv_rf_if slave (write/read ports, o_rdata, o_init_done)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | writing zero to word[r_cnt] each cycle, core writes ignored
// ST_RUN  | normal operation, core owns both ports
module herv_rf_ram
   import herv_rf_ram_pkg::*;
#(
   parameter int unsigned width    = 16,
   parameter int unsigned csr_regs = 4,
   parameter int unsigned depth    = calc_depth(width, csr_regs),
   parameter bit          zero_x0  = 1'b1
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   herv_rf_if.slave bus
);
   localparam int unsigned aw = calc_aw(depth);
   // Low address bits select the word within one 32-bit register.
   localparam int unsigned sh = 5 - l2w(width);
   localparam logic [aw:0] CNT_LAST = (aw+1)'(depth - 1);

   rf_state_e r_state;
   logic [aw:0] r_cnt;
   logic r_init_done;
   // o_rdata is forced to zero until the first RUN-state read lands.
   logic r_rd_zero;

   logic             w_is_x0;
   logic             w_mem_wen;
   logic [aw-1:0]    w_mem_waddr;
   logic [width-1:0] w_mem_wdata;
   logic             w_mem_ren;
   logic [width-1:0] w_mem_q;

   assign w_is_x0 = zero_x0 && ((bus.i_waddr >> sh) == '0);

   always_comb begin
      w_mem_wen   = 1'b1;
      w_mem_waddr = r_cnt[aw-1:0];
      w_mem_wdata = '0;
      if (r_state == ST_RUN) begin
         w_mem_wen   = bus.i_wen & ~w_is_x0;
         w_mem_waddr = bus.i_waddr;
         w_mem_wdata = bus.i_wdata;
      end
   end

   assign w_mem_ren = bus.i_ren & (r_state == ST_RUN);

   herv_rf_sram #(
      .width (width),
      .depth (depth),
      .aw    (aw)
   ) u_sram (
      .i_clk   (i_clk),
      .i_wen   (w_mem_wen),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_ren   (w_mem_ren),
      .i_raddr (bus.i_raddr),
      .o_q     (w_mem_q)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_rd_zero   <= 1'b1;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (bus.i_ren) r_rd_zero <= 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.i_ren) r_rd_zero <= 1'b0;
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign bus.o_rdata     = r_rd_zero ? '0 : w_mem_q;
   assign bus.o_init_done = r_init_done;
endmodule

// File: tb/tb_herv_rf_ram.sv
module tb_herv_rf_ram;
   localparam int DEPTH = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   herv_rf_if #(.width(16), .csr_regs(4)) bus ();

   herv_rf_ram #(
      .width    (16),
      .csr_regs (4),
      .zero_x0  (1'b1)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference: after a reset release the RAM reads as all zeros once the
   // clear has had DEPTH edges; before that writes are ignored and reads
   // give zero. x0 occupies the two 16-bit words with address/2 == 0.
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_rdata;
   logic        m_run;
   int          m_edges;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [6:0] wa, input logic [15:0] wd,
                        input logic re, input logic [6:0] ra);
      bus.i_wen   = we;
      bus.i_waddr = wa;
      bus.i_wdata = wd;
      bus.i_ren   = re;
      bus.i_raddr = ra;
   endtask

   task automatic tick(input string tag);
      logic we, re;
      logic [6:0] wa, ra;
      logic [15:0] wd;
      we = bus.i_wen; re = bus.i_ren;
      wa = bus.i_waddr; ra = bus.i_raddr; wd = bus.i_wdata;
      @(posedge clk);
      #1;
      if (m_run) begin
         if (re) m_rdata = m_mem[ra];
         if (we && (int'(wa) / 2) != 0) m_mem[wa] = wd;
      end else begin
         if (re) m_rdata = 16'h0000;
         m_edges++;
         if (m_edges == DEPTH) m_run = 1'b1;
      end
      check({tag, ".rdata"}, bus.o_rdata, m_rdata);
      check({tag, ".done"}, {15'd0, bus.o_init_done}, {15'd0, m_run});
   endtask

   // Assert reset, check the immediate async effect, release just after an edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m_run = 1'b0; m_edges = 0; m_rdata = 16'h0000;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
      check({tag, ".rst_done"}, {15'd0, bus.o_init_done}, 16'h0000);
      check({tag, ".rst_rdata"}, bus.o_rdata, 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      drive(1'b0, 7'd0, 16'd0, 1'b0, 7'd0);
      m_run = 1'b0; m_edges = 0; m_rdata = 16'h0000;
      #2;
      do_reset("por");

      // Clear with core writes hammering throughout; done must rise on edge 128.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 7'($urandom_range(0, 127)), 16'($urandom), 1'($urandom), 7'($urandom_range(0, 127)));
         tick("init");
      end
      check("init_done_at_128", {15'd0, bus.o_init_done}, 16'h0001);
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 7'd0, 16'd0, 1'b1, 7'(a));
         tick("readzero");
         check("readzero_const", bus.o_rdata, 16'h0000);
      end

      // Write then read back, then hold with ren low.
      drive(1'b1, 7'h25, 16'hA5C3, 1'b0, 7'd0); tick("wr25");
      drive(1'b0, 7'h00, 16'h0000, 1'b1, 7'h25); tick("rd25");
      check("rd25_const", bus.o_rdata, 16'hA5C3);
      drive(1'b1, 7'h30, 16'h5555, 1'b0, 7'h30); tick("hold1");
      tick("hold2");
      check("hold_const", bus.o_rdata, 16'hA5C3);

      // Read-first on a same-address collision.
      drive(1'b1, 7'h40, 16'hBEEF, 1'b0, 7'd0); tick("wr40");
      drive(1'b1, 7'h40, 16'h1234, 1'b1, 7'h40); tick("coll40");
      check("coll_old_const", bus.o_rdata, 16'hBEEF);
      drive(1'b0, 7'h00, 16'h0000, 1'b1, 7'h40); tick("rd40");
      check("coll_new_const", bus.o_rdata, 16'h1234);

      // x0 words drop writes, x1 does not.
      drive(1'b1, 7'h00, 16'hFFFF, 1'b0, 7'd0); tick("wrx0a");
      drive(1'b1, 7'h01, 16'hFFFF, 1'b0, 7'd0); tick("wrx0b");
      drive(1'b1, 7'h02, 16'hFFFF, 1'b0, 7'd0); tick("wrx1");
      drive(1'b0, 7'h00, 16'h0000, 1'b1, 7'h00); tick("rdx0a");
      check("x0a_const", bus.o_rdata, 16'h0000);
      drive(1'b0, 7'h00, 16'h0000, 1'b1, 7'h01); tick("rdx0b");
      check("x0b_const", bus.o_rdata, 16'h0000);
      drive(1'b0, 7'h00, 16'h0000, 1'b1, 7'h02); tick("rdx1");
      check("x1_const", bus.o_rdata, 16'hFFFF);

      // Random RUN traffic, with some forced read/write address collisions.
      for (int i = 0; i < 10000; i++) begin
         logic [6:0] wa;
         wa = 7'($urandom_range(0, 127));
         drive(1'($urandom), wa, 16'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? wa : 7'($urandom_range(0, 127)));
         tick("rand");
      end

      // Reset mid-RUN, then again at cycle 60 of INIT.
      drive(1'b0, 7'd0, 16'd0, 1'b1, 7'h02); tick("pre_rst");
      do_reset("runrst");
      for (int i = 0; i < 60; i++) begin
         drive(1'b1, 7'h25, 16'hDEAD, 1'b1, 7'h25);
         tick("init60");
      end
      do_reset("initrst");
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 7'h40, 16'hCAFE, 1'b1, 7'h40);
         tick("reinit");
      end
      check("reinit_done", {15'd0, bus.o_init_done}, 16'h0001);
      drive(1'b0, 7'd0, 16'd0, 1'b1, 7'h25); tick("post25");
      check("post25_const", bus.o_rdata, 16'h0000);
      drive(1'b0, 7'd0, 16'd0, 1'b1, 7'h40); tick("post40");
      check("post40_const", bus.o_rdata, 16'h0000);
      drive(1'b0, 7'd0, 16'd0, 1'b1, 7'h02); tick("post02");
      check("post02_const", bus.o_rdata, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/herv_rf_ram.md
HERV_RF_RAM -- requirements
Module: herv_rf_ram

Interface
REQ-001 Parameter width, default 16, RAM data width; same value as the upstream RF RAM interface.
REQ-002 Parameter csr_regs, default 4, number of CSR registers stored after the 32 GPRs.
REQ-003 Parameter depth, default 32*(32+csr_regs)/width rounded up to a power of two, word count (128 at defaults); aw = clog2(depth).
REQ-004 Parameter zero_x0, default 1; when 1, writes to words belonging to register x0 are suppressed.
REQ-005 i_clk input 1: single clock; all state updates on the rising edge.
REQ-006 i_rst_n input 1: reset, asynchronous and active-low.
REQ-007 i_waddr input aw: write word address.
REQ-008 i_wdata input width: write data.
REQ-009 i_wen input 1: write strobe.
REQ-010 i_raddr input aw: read word address.
REQ-011 i_ren input 1: read strobe.
REQ-012 o_rdata output width: registered read data.
REQ-013 o_init_done output 1: high once the clear sequence has completed.

Function
REQ-014 FSM has two states: INIT and RUN; reset forces INIT.
REQ-015 INIT: clear counter starts at 0, writes zero to word[counter] every cycle, and increments by 1.
REQ-016 INIT->RUN on the cycle the counter write reaches depth-1; o_init_done rises the following cycle and stays high until reset.
REQ-017 The clear takes exactly depth cycles after reset release (128 at defaults).
REQ-018 In INIT, i_wen is ignored and no user write reaches the array.
REQ-019 In INIT, i_ren loads o_rdata with zero.
REQ-020 RUN: i_wen=1 writes i_wdata to word[i_waddr] at the clock edge.
REQ-021 RUN: i_ren=1 loads o_rdata with word[i_raddr] at the clock edge, so read latency is 1 cycle; with i_ren=0, o_rdata holds its value.
REQ-022 Same-cycle read and write to the same address is read-first: o_rdata returns the old word, and the new word is visible from the next read.
REQ-023 With zero_x0=1, a write whose upper address bits (register index, the top aw-(5-clog2(width)) bits) equal 0 is dropped; word x0 always reads 0.
REQ-024 Reads and writes to different addresses in the same cycle are independent.
REQ-025 The clear counter is aw+1 bits wide so it cannot wrap back to 0 before the RUN transition.

Reset
REQ-026 Asserting i_rst_n low, including mid-INIT or mid-RUN, immediately sets state=INIT, counter=0, o_rdata=0, o_init_done=0.
REQ-027 Array contents are not reset asynchronously; they are re-cleared by INIT after reset release.
REQ-028 On the first edge after deassertion, word 0 is cleared.

Structure
REQ-029 The shared package holds the raw/l2w/aw/depth computation functions and the INIT/RUN state encoding, and the upstream RF RAM interface uses the same functions.
REQ-030 The storage array is a sub-module, herv_rf_sram (1 write port, 1 registered read port, read-first), so a foundry macro can replace it.
REQ-031 The FSM, clear counter, write muxing and x0 masking live in herv_rf_ram.

Verification
REQ-032 Release reset at defaults, hold i_wen=1 throughout -> o_init_done rises exactly 128 cycles after release; a subsequent read of every address returns 0x0000.
REQ-033 RUN: write 0xA5C3 to address 0x25, then i_ren to 0x25 the next cycle -> o_rdata=0xA5C3 one cycle later; o_rdata holds after i_ren drops.
REQ-034 RUN: same cycle write 0x1234 and read address 0x40, old value 0xBEEF -> o_rdata=0xBEEF; the next read gives 0x1234.
REQ-035 zero_x0=1: write 0xFFFF to address 0x00 and 0x01 -> both read 0x0000; a write to 0x02 (x1) reads back 0xFFFF.
REQ-036 Assert i_rst_n low at cycle 60 of INIT, then release -> o_init_done=0 and o_rdata=0 immediately; done rises 128 cycles after the second release; previously written words read 0.
REQ-037 Random RUN traffic against a reference array model -> zero mismatches over 10,000 cycles.
